// File: rtl/divider_pkg.sv
// divider_pkg: shared state encoding, default width and magnitude helper for divider_seq.
package divider_pkg;
  localparam int DIV_WIDTH = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, SIGN = 2'd2, DONE = 2'd3} div_state_t;
  function automatic logic [32:0] abs_ext(input logic signed [32:0] v);
    return v[32] ? 33'(-v) : v;
  endfunction
endpackage

// File: rtl/divider_seq_if.sv
// divider_seq_if: operand and result valid/ready handshakes of divider_seq.
interface divider_seq_if
  import divider_pkg::*;
#(parameter int WIDTH = DIV_WIDTH);
  logic             VALID_i;
  logic             READY_o;
  logic [WIDTH-1:0] DIN1_i;
  logic [WIDTH-1:0] DIN2_i;
  logic             VALID_o;
  logic             READY_i;
  logic [WIDTH-1:0] QUOT_o;
  logic [WIDTH-1:0] REM_o;
  logic             DIV0_o;
  modport master (output VALID_i, DIN1_i, DIN2_i, READY_i,
                  input  READY_o, VALID_o, QUOT_o, REM_o, DIV0_o);
  modport slave  (input  VALID_i, DIN1_i, DIN2_i, READY_i,
                  output READY_o, VALID_o, QUOT_o, REM_o, DIV0_o);
endinterface

// File: rtl/div_step.sv
// div_step: one restoring-division iteration; trial subtract is a ripple-carry add of ~divisor + 1.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_rem,
  input  logic         i_bit,
  input  logic [W:0]   i_dvs,
  output logic [W-1:0] o_rem,
  output logic         o_q
);
  logic [W:0] w_sh, w_b, w_s, w_c;
  assign w_sh   = {i_rem, i_bit};
  assign w_b    = ~i_dvs;
  assign w_c[0] = 1'b1;
  for (genvar g = 0; g <= W; g++) begin : g_fa
    assign w_s[g] = w_sh[g] ^ w_b[g] ^ w_c[g];
    if (g < W) begin : g_cy
      assign w_c[g+1] = (w_sh[g] & w_b[g]) | (w_c[g] & (w_sh[g] ^ w_b[g]));
    end
  end
  // operands are below 2^W, so the top sum bit is the sign of the trial difference
  assign o_q   = ~w_s[W];
  assign o_rem = o_q ? w_s[W-1:0] : w_sh[W-1:0];
endmodule

// File: rtl/divider_seq.sv
// divider_seq: iterative signed divider, one quotient bit per clock with sign fix-up.
// Define DIVIDER_FAST_SPECIAL_EN to finish divide-by-zero and overflow without iterating.
module divider_seq
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic CLK_i,
  input  logic RSTn_i,
  divider_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CALC = CALC;
  localparam logic [1:0] S_SIGN = SIGN;
  localparam logic [1:0] S_DONE = DONE;
  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem, r_quot, r_quot_o, r_rem_o;
  logic [WIDTH:0]   r_dvs;
  logic             r_sign_q, r_sign_r, r_div0, r_div0_o, r_valid;
  logic [WIDTH-1:0] w_rem;
  logic             w_q, w_zero;
  assign w_zero = bus.DIN2_i == '0;
`ifdef DIVIDER_FAST_SPECIAL_EN
  logic w_ovf;
  assign w_ovf = (bus.DIN1_i == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.DIN2_i);
`endif
  div_step #(.W(WIDTH)) u_step (
    .i_rem(r_rem),
    .i_bit(r_quot[WIDTH-1]),
    .i_dvs(r_dvs),
    .o_rem(w_rem),
    .o_q  (w_q)
  );
  assign bus.READY_o = RSTn_i && (r_state == S_IDLE);
  assign bus.VALID_o = r_valid;
  assign bus.QUOT_o  = r_quot_o;
  assign bus.REM_o   = r_rem_o;
  assign bus.DIV0_o  = r_div0_o;
  always_ff @(posedge CLK_i) begin
    if (!RSTn_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_dvs    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_div0   <= 1'b0;
      r_valid  <= 1'b0;
      r_quot_o <= '0;
      r_rem_o  <= '0;
      r_div0_o <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.VALID_i) begin
          r_quot   <= WIDTH'(abs_ext(33'(signed'(bus.DIN1_i))));
          r_dvs    <= (WIDTH+1)'(abs_ext(33'(signed'(bus.DIN2_i))));
          // a zero divisor leaves an all-ones quotient that must not be negated
          r_sign_q <= !w_zero && (bus.DIN1_i[WIDTH-1] ^ bus.DIN2_i[WIDTH-1]);
          r_sign_r <= bus.DIN1_i[WIDTH-1];
          r_div0   <= w_zero;
          r_rem    <= '0;
          r_cnt    <= CW'(WIDTH-1);
          r_state  <= S_CALC;
`ifdef DIVIDER_FAST_SPECIAL_EN
          if (w_zero || w_ovf) begin
            r_quot  <= w_zero ? '1 : {1'b1, {(WIDTH-1){1'b0}}};
            r_rem   <= w_zero ? WIDTH'(abs_ext(33'(signed'(bus.DIN1_i)))) : '0;
            r_state <= S_SIGN;
          end
`endif
        end
        S_CALC: begin
          r_rem  <= w_rem;
          r_quot <= {r_quot[WIDTH-2:0], w_q};
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= S_SIGN;
        end
        S_SIGN: begin
          r_quot_o <= r_sign_q ? -r_quot : r_quot;
          r_rem_o  <= r_sign_r ? -r_rem : r_rem;
          r_div0_o <= r_div0;
          r_valid  <= 1'b1;
          r_state  <= S_DONE;
        end
        default: if (bus.READY_i) begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: randomized and directed checks of divider_seq against an arithmetic reference.
module tb_divider_seq;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int tests = 0;
  int fails = 0;
  divider_seq_if #(.WIDTH(32)) bus ();
  divider_seq #(.WIDTH(32)) dut (.CLK_i(clk), .RSTn_i(rstn), .bus(bus));
  always #5 clk = ~clk;

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic d0, output int lat);
    longint sa, sb;
    logic special;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    special = (b == 32'd0) || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      d0 = 1'b1;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      d0 = 1'b0;
    end
`ifdef DIVIDER_FAST_SPECIAL_EN
    lat = special ? 2 : 34;
`else
    lat = special ? 34 : 34;
`endif
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold, input string name);
    logic [31:0] eq, er, sq, sr;
    logic ed, sd;
    int elat, n;
    model(a, b, eq, er, ed, elat);
    @(negedge clk);
    tests++;
    if (bus.READY_o !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_before_accept got=%b want=1", name, bus.READY_o);
    end
    bus.VALID_i = 1'b1;
    bus.DIN1_i = a;
    bus.DIN2_i = b;
    bus.READY_i = (hold == 0);
    @(posedge clk);
    #1 bus.VALID_i = 1'b0;
    n = 0;
    while (bus.VALID_o !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    tests++;
    if (n + 1 !== elat) begin
      fails++;
      $display("FAIL %s latency got=%0d want=%0d", name, n + 1, elat);
    end
    tests++;
    if (bus.QUOT_o !== eq) begin
      fails++;
      $display("FAIL %s quot got=%h want=%h", name, bus.QUOT_o, eq);
    end
    tests++;
    if (bus.REM_o !== er) begin
      fails++;
      $display("FAIL %s rem got=%h want=%h", name, bus.REM_o, er);
    end
    tests++;
    if (bus.DIV0_o !== ed) begin
      fails++;
      $display("FAIL %s div0 got=%b want=%b", name, bus.DIV0_o, ed);
    end
    sq = bus.QUOT_o;
    sr = bus.REM_o;
    sd = bus.DIV0_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      tests++;
      if ({bus.VALID_o, bus.READY_o, bus.QUOT_o, bus.REM_o, bus.DIV0_o} !== {2'b10, sq, sr, sd}) begin
        fails++;
        $display("FAIL %s hold_stable cyc=%0d got v=%b r=%b q=%h rem=%h d0=%b want v=1 r=0 q=%h rem=%h d0=%b",
                 name, i, bus.VALID_o, bus.READY_o, bus.QUOT_o, bus.REM_o, bus.DIV0_o, sq, sr, sd);
      end
      bus.VALID_i = 1'b1;
      bus.DIN1_i = $urandom;
      bus.DIN2_i = $urandom_range(1, 9);
    end
    if (hold > 0) begin
      @(negedge clk);
      bus.VALID_i = 1'b0;
      bus.READY_i = 1'b1;
    end
    @(posedge clk);
    #1 tests++;
    if ({bus.VALID_o, bus.READY_o} !== 2'b01) begin
      fails++;
      $display("FAIL %s after_handshake got valid=%b ready=%b want valid=0 ready=1", name, bus.VALID_o, bus.READY_o);
    end
  endtask

  task automatic test_reset();
    bus.VALID_i = 1'b0;
    bus.READY_i = 1'b1;
    bus.DIN1_i = '0;
    bus.DIN2_i = '0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({bus.READY_o, bus.VALID_o, bus.QUOT_o, bus.REM_o, bus.DIV0_o} !== 67'd0) begin
      fails++;
      $display("FAIL reset_values got ready=%b valid=%b q=%h r=%h d0=%b want all 0",
               bus.READY_o, bus.VALID_o, bus.QUOT_o, bus.REM_o, bus.DIV0_o);
    end
    rstn = 1'b1;
    #1 tests++;
    if (bus.READY_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready got=%b want=1", bus.READY_o);
    end
  endtask

  task automatic test_directed();
    run_op(32'd100, 32'd7, 0, "pos_pos");
    run_op(-32'sd100, 32'd7, 0, "neg_pos");
    run_op(32'd100, -32'sd7, 0, "pos_neg");
    run_op(-32'sd100, -32'sd7, 0, "neg_neg");
    run_op(32'd5, 32'd0, 0, "div_zero");
    run_op(32'h8000_0000, 32'd0, 0, "minneg_div_zero");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, "overflow");
    run_op(32'h8000_0000, 32'd1, 0, "minneg_by_one");
    run_op(32'd0, 32'd5, 0, "zero_dividend");
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 0, "maxpos_by_minneg");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 20);
        3: b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op(a, b, 0, "random");
    end
  endtask

  task automatic test_backpressure();
    run_op(32'd1000, 32'd33, 10, "backpressure");
    run_op(32'd77, -32'sd5, 0, "back_to_back");
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    bus.VALID_i = 1'b1;
    bus.DIN1_i = 32'd1000;
    bus.DIN2_i = 32'd3;
    bus.READY_i = 1'b1;
    @(posedge clk);
    #1 bus.VALID_i = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1 tests++;
    if (bus.READY_o !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_ready got=%b want=0", bus.READY_o);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1 tests++;
    if ({bus.READY_o, bus.VALID_o} !== 2'b10) begin
      fails++;
      $display("FAIL mid_reset_release got ready=%b valid=%b want ready=1 valid=0", bus.READY_o, bus.VALID_o);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.VALID_o === 1'b1) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL mid_reset_abandoned valid_cycles got=%0d want=0", seen);
    end
    run_op(32'd9, 32'd3, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
